pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the CPU datapath. Splits a WIDTH-bit carry chain into STAGES equal chunks, one chunk per registered stage, with a valid/ready handshake at both ends so the ALU can stall it. Sustains one operation per cycle with a fixed STAGES-cycle latency and supports add and subtract.

---
 rtl/cpu_alu_pkg.sv | 18 +
 rtl/adder_slice.sv | 33 +++
 rtl/pipelined_adder.sv | 142 ++++++++++++++
 tb/tb_pipelined_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared definitions for the CPU ALU datapath blocks.
//   alu_op_e      - add/subtract operation select
//   ALU_WIDTH     - default datapath width
//   stages_legal  - checks a WIDTH/STAGES split for the pipelined adder
package cpu_alu_pkg;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  localparam int ALU_WIDTH = 32;

  function automatic bit stages_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: CW-bit ripple-carry adder chunk used by one pipeline stage.
//   a_i, b_i  in  CW  operand chunks (b already inverted for subtract)
//   c_i       in  1   carry into bit 0
//   s_o       out CW  chunk sum
//   c_o       out 1   carry out of the chunk MSB
//   c_msb_o   out 1   carry into the chunk MSB (signed-overflow detection)
module adder_slice #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          c_i,
  output logic [CW-1:0] s_o,
  output logic          c_o,
  output logic          c_msb_o
);

  logic [CW:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < CW; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = c[CW];
  assign c_msb_o = c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: skewed, STAGES-deep add/subtract pipeline with valid/ready
// at both ends. Stage s adds chunk s; unconsumed upper operand chunks and the
// finished lower sum chunks travel with the operation.
//   clk_i, rst_n_i        clock, async active-low reset
//   valid_i/ready_o       input handshake; sub_i, A_i, B_i operation
//   valid_o/ready_i       output handshake; S_o, C_out_o result
//   ovf_o, zero_o         signed overflow / zero flags (ADDER_FLAGS_EN only)
// Optional feature macro: ADDER_FLAGS_EN.
module pipelined_adder
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] S_o,
  output logic             C_out_o
`ifdef ADDER_FLAGS_EN
  ,
  output logic             ovf_o,
  output logic             zero_o
`endif
);

  localparam int CW = WIDTH / STAGES;

  if (!stages_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: STAGES must divide WIDTH and be in 1..WIDTH");
  end

  alu_op_e op;
  assign op = alu_op_e'(sub_i);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;

  assign ready_o = ld[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int RIN  = WIDTH - s * CW;   // operand bits still to be added
    localparam int ROUT = RIN - CW;         // operand bits passed onward
    localparam int SW   = (s + 1) * CW;     // sum bits finished after this stage

    logic [RIN-1:0] a_in, b_in;
    logic           c_in, v_in;
    logic [CW-1:0]  s_chunk;
    logic           c_chunk;
    logic [SW-1:0]  sum_d, sum_q;
    logic           c_q, vld_q;

    // A stage loads when any stage at or beyond it has a hole, or the output
    // drains: everything downstream shifts forward, so bubbles collapse.
    assign ld[s]  = ready_i | ~(&vld[STAGES-1:s]);
    assign vld[s] = vld_q;

    if (s == 0) begin : g_head
      assign a_in  = A_i;
      assign b_in  = (op == ALU_SUB) ? ~B_i : B_i;
      assign c_in  = (op == ALU_SUB);
      assign v_in  = valid_i;
      assign sum_d = s_chunk;
    end else begin : g_body
      assign a_in  = g_st[s-1].g_fwd.a_q;
      assign b_in  = g_st[s-1].g_fwd.b_q;
      assign c_in  = g_st[s-1].c_q;
      assign v_in  = g_st[s-1].vld_q;
      assign sum_d = {s_chunk, g_st[s-1].sum_q};
    end

`ifdef ADDER_FLAGS_EN
    localparam bit USE_FLAGS = (s == STAGES - 1);
`else
    localparam bit USE_FLAGS = 1'b0;
`endif

    if (USE_FLAGS) begin : g_flags
      logic c_msb;
      logic ovf_q, zero_q;
      adder_slice #(.CW(CW)) u_slice (
        .a_i(a_in[CW-1:0]), .b_i(b_in[CW-1:0]), .c_i(c_in),
        .s_o(s_chunk), .c_o(c_chunk), .c_msb_o(c_msb)
      );
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (ld[s]) begin
          ovf_q  <= c_msb ^ c_chunk;
          zero_q <= (sum_d == '0);
        end
      end
    end else begin : g_noflags
      logic c_msb_unused;
      adder_slice #(.CW(CW)) u_slice (
        .a_i(a_in[CW-1:0]), .b_i(b_in[CW-1:0]), .c_i(c_in),
        .s_o(s_chunk), .c_o(c_chunk), .c_msb_o(c_msb_unused)
      );
    end

    if (ROUT > 0) begin : g_fwd
      logic [ROUT-1:0] a_q, b_q;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[s]) begin
          a_q <= a_in[RIN-1:CW];
          b_q <= b_in[RIN-1:CW];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (ld[s]) begin
        vld_q <= v_in;
        c_q   <= c_chunk;
        sum_q <= sum_d;
      end
    end
  end

  assign valid_o = vld[STAGES-1];
  assign S_o     = g_st[STAGES-1].sum_q;
  assign C_out_o = g_st[STAGES-1].c_q;
`ifdef ADDER_FLAGS_EN
  assign ovf_o   = g_st[STAGES-1].g_flags.ovf_q;
  assign zero_o  = g_st[STAGES-1].g_flags.zero_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomized checks of pipelined_adder at
// STAGES = 4 (main instance), 1, 2, 8 and 32, all sharing one input stream.
module tb_pipelined_adder;

  localparam int W  = 32;
  localparam int ND = 5;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            valid_i, sub_i, ready_i;
  logic [W-1:0]    A_i, B_i;
  logic [ND-1:0]   ready_o, valid_o, C_out_o;
  logic [W-1:0]    S_o [ND];
`ifdef ADDER_FLAGS_EN
  logic [ND-1:0]   ovf_o, zero_o;
  localparam logic [W+2:0] CMP_MASK = '1;
`else
  localparam logic [W+2:0] CMP_MASK = {2'b00, {(W+1){1'b1}}};
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {zero, ovf, carry, sum} from plain integer arithmetic.
  function automatic logic [W+2:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
    longint       sa, sb, r;
    logic [W-1:0] s;
    logic         c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    s  = r[W-1:0];
    c  = sub ? (a >= b) : (({32'b0, a} + {32'b0, b}) > 64'h0000_0000_FFFF_FFFF);
    return {(s == '0), v, c, s};
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  for (genvar k = 0; k < ND; k++) begin : g_dut
    localparam int ST = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 8 : 32;
    logic [W+2:0] got, prev_got;
    logic [W+2:0] exp_q[$];
    logic         prev_stall;
    logic         of_k, zf_k;

    pipelined_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .valid_i(valid_i), .ready_o(ready_o[k]),
      .sub_i(sub_i), .A_i(A_i), .B_i(B_i),
      .valid_o(valid_o[k]), .ready_i(ready_i),
      .S_o(S_o[k]), .C_out_o(C_out_o[k])
`ifdef ADDER_FLAGS_EN
      , .ovf_o(ovf_o[k]), .zero_o(zero_o[k])
`endif
    );

`ifdef ADDER_FLAGS_EN
    assign of_k = ovf_o[k];
    assign zf_k = zero_o[k];
`else
    assign of_k = 1'b0;
    assign zf_k = 1'b0;
`endif
    assign got = {zf_k, of_k, C_out_o[k], S_o[k]};

    always @(negedge clk_i) begin : mon
      logic [W+2:0] e;
      if (!rst_n_i) begin
        exp_q.delete();
        prev_stall <= 1'b0;
      end else begin
        if (prev_stall) begin
          chk($sformatf("dut%0d hold valid", k), valid_o[k], 1);
          chk($sformatf("dut%0d hold data", k), got & CMP_MASK, prev_got & CMP_MASK);
        end
        chk($sformatf("dut%0d ready_o", k), ready_o[k],
            ready_i || (exp_q.size() < ST));
        if (valid_o[k] && ready_i) begin
          chk($sformatf("dut%0d op pending", k), exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("dut%0d result", k), got & CMP_MASK, e & CMP_MASK);
          end
        end
        if (valid_i && ready_o[k]) exp_q.push_back(ref_op(A_i, B_i, sub_i));
        prev_stall <= valid_o[k] && !ready_i;
        prev_got   <= got;
      end
    end
  end

  // One operation into an empty pipeline; checks latency and the result.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
    @(posedge clk_i); #1;
    valid_i = 1'b1; A_i = a; B_i = b; sub_i = sub;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 chk({tag, " early"}, valid_o[0], 0);
    @(posedge clk_i); #1;
    chk({tag, " valid"}, valid_o[0], 1);
    chk({tag, " S"}, S_o[0], es);
    chk({tag, " C"}, C_out_o[0], ec);
`ifdef ADDER_FLAGS_EN
    chk({tag, " ovf"}, ovf_o[0], eo);
    chk({tag, " zero"}, zero_o[0], ez);
`else
    if (eo || ez) n_run += 0;
`endif
  endtask

  initial begin
    int sent, drained;
    rst_n_i = 1'b0; valid_i = 1'b0; sub_i = 1'b0; ready_i = 1'b1; A_i = '0; B_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst valid_o", valid_o, '0);
    chk("rst S_o", S_o[0], '0);
    chk("rst C_out_o", C_out_o, '0);
`ifdef ADDER_FLAGS_EN
    chk("rst ovf_o", ovf_o, '0);
    chk("rst zero_o", zero_o, '0);
`endif
    rst_n_i = 1'b1;
    #1 chk("rst ready_o", ready_o, {ND{1'b1}});

    directed("add wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    directed("sub 5-7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub 7-5", 32'd7, 32'd5, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    directed("add ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub ovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Six back-to-back ops with the output stalled for cycles 2..4.
    @(posedge clk_i); #1;
    sent = 0; drained = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      valid_i = (sent < 6);
      A_i = rnd_val(); B_i = rnd_val(); sub_i = 1'($urandom_range(0, 1));
      ready_i = !(cyc >= 2 && cyc < 5);
      #1;
      if (cyc == 4) chk("stall full ready_o", ready_o[0], 0);
      if (valid_i && ready_o[0]) sent++;
      if (valid_o[0] && ready_i) drained++;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    chk("stall sent", sent, 6);
    chk("stall drained", drained, 6);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; A_i = rnd_val(); B_i = rnd_val(); sub_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("midrst valid_o", valid_o, '0);
    chk("midrst S_o", S_o[0], '0);
    chk("midrst C_out_o", C_out_o, '0);
`ifdef ADDER_FLAGS_EN
    chk("midrst ovf_o", ovf_o, '0);
    chk("midrst zero_o", zero_o, '0);
`endif
    @(posedge clk_i); #1 rst_n_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1 chk("no stale result", valid_o, '0);
    end
    directed("post rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 7);
      A_i = rnd_val(); B_i = rnd_val(); sub_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    chk("dut0 drained", g_dut[0].exp_q.size(), 0);
    chk("dut1 drained", g_dut[1].exp_q.size(), 0);
    chk("dut2 drained", g_dut[2].exp_q.size(), 0);
    chk("dut3 drained", g_dut[3].exp_q.size(), 0);
    chk("dut4 drained", g_dut[4].exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
